// File: rtl/uart_tx_arbiter_if.sv
`timescale 1ns/1ps
// Byte-source / UART handshake bundle shared by the trace stream, control stream and transmitter.
interface uart_tx_arbiter_if;
    logic       trace_avail;
    logic [7:0] trace_byte;
    logic       trace_next;
    logic       ctl_avail;
    logic [7:0] ctl_byte;
    logic       ctl_last;
    logic       ctl_next;
    logic       tx_free;
    logic       transmit;
    logic [7:0] tx_byte;
    logic       grant_ctl;
    logic [7:0] burst_cnt;

    modport master (
        output trace_avail, trace_byte, ctl_avail, ctl_byte, ctl_last, tx_free,
        input  trace_next, ctl_next, transmit, tx_byte, grant_ctl, burst_cnt
    );

    modport slave (
        input  trace_avail, trace_byte, ctl_avail, ctl_byte, ctl_last, tx_free,
        output trace_next, ctl_next, transmit, tx_byte, grant_ctl, burst_cnt
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// Shares one UART transmitter between the trace stream and the control stream, switching
// owners only at trace-frame or control-message boundaries, with a trace burst limit.
module uart_tx_arbiter #(
    parameter int FRAME_LEN = 16,
    parameter int MAX_BURST = 4,
    parameter int HOLDOFF   = 2
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int IDX_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME_LEN - 1);
    localparam logic [HOLD_W-1:0] HOLD_LD   = HOLD_W'(HOLDOFF);
    localparam logic [7:0]        BURST_MAX = 8'(MAX_BURST);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TRACE = 2'd1;
    localparam logic [1:0] S_CTL   = 2'd2;

    logic [1:0]        r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [HOLD_W-1:0] r_hold;
    logic [7:0]        r_burst;
    logic [7:0]        r_tx_byte;
    logic              r_transmit;
    logic              r_trace_next;
    logic              r_ctl_next;
    logic              r_grant;

    logic w_idle;
    logic w_pick_ctl;
    logic w_sel_trace;
    logic w_sel_ctl;
    logic w_ready;
    logic w_issue_trace;
    logic w_issue_ctl;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v >= BURST_MAX) ? BURST_MAX : v + 8'd1;
    endfunction

    // In IDLE control wins only when trace is absent or has used up its burst allowance.
    assign w_idle        = (r_state == S_IDLE);
    assign w_pick_ctl    = bus.ctl_avail && (!bus.trace_avail || (r_burst >= BURST_MAX));
    assign w_sel_ctl     = (r_state == S_CTL)   || (w_idle && w_pick_ctl);
    assign w_sel_trace   = (r_state == S_TRACE) || (w_idle && !w_pick_ctl);
    assign w_ready       = (r_hold == '0) && bus.tx_free;
    assign w_issue_trace = w_ready && w_sel_trace && bus.trace_avail;
    assign w_issue_ctl   = w_ready && w_sel_ctl && bus.ctl_avail;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_hold       <= '0;
            r_burst      <= 8'd0;
            r_tx_byte    <= 8'h00;
            r_transmit   <= 1'b0;
            r_trace_next <= 1'b0;
            r_ctl_next   <= 1'b0;
            r_grant      <= 1'b0;
        end else begin
            r_transmit   <= w_issue_trace || w_issue_ctl;
            r_trace_next <= w_issue_trace;
            r_ctl_next   <= w_issue_ctl;

            if (w_issue_trace || w_issue_ctl) begin
                r_hold <= HOLD_LD;
            end else if (r_hold != '0) begin
                r_hold <= r_hold - 1'b1;
            end

            if (w_issue_trace) begin
                r_tx_byte <= bus.trace_byte;
                r_grant   <= 1'b0;
                if (r_idx == LAST_IDX) begin
                    r_idx   <= '0;
                    r_burst <= sat_inc(r_burst);
                    r_state <= S_IDLE;
                end else begin
                    r_idx   <= r_idx + 1'b1;
                    r_state <= S_TRACE;
                end
            end else if (w_issue_ctl) begin
                r_tx_byte <= bus.ctl_byte;
                r_grant   <= 1'b1;
                if (bus.ctl_last) begin
                    r_burst <= 8'd0;
                    r_state <= S_IDLE;
                end else begin
                    r_state <= S_CTL;
                end
            end else if (r_state != S_CTL) begin
                // Grant lingers one cycle past the final control byte, then drops.
                r_grant <= 1'b0;
            end
        end
    end

    assign bus.transmit   = r_transmit;
    assign bus.tx_byte    = r_tx_byte;
    assign bus.trace_next = r_trace_next;
    assign bus.ctl_next   = r_ctl_next;
    assign bus.grant_ctl  = r_grant;
    assign bus.burst_cnt  = r_burst;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// Bench for uart_tx_arbiter: a per-cycle vector table for reset/holdoff/single-byte control,
// then scoreboarded stream scenarios driven by simple trace and control source models.
module tb_uart_tx_arbiter;
    typedef struct {
        logic       rst;
        logic       tx_free;
        logic       tr_av;
        logic [7:0] tr_b;
        logic       c_av;
        logic [7:0] c_b;
        logic       c_last;
        logic       e_tx;
        logic [7:0] e_byte;
        logic       e_trn;
        logic       e_ctn;
        logic       e_grant;
        logic [7:0] e_burst;
    } vec_t;

    typedef struct {
        bit         is_ctl;
        logic [7:0] data;
        int         burst;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } msg_t;

    logic clk = 1'b0;
    logic rst;
    logic       d_trace_avail, d_ctl_avail, d_ctl_last, d_tx_free;
    logic [7:0] d_trace_byte, d_ctl_byte;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   last_tx = -1;
    int   tx_count = 0;
    int   tr_cnt = 0;
    int   tr_limit = 0;
    int   max_b = 4;
    bit   tr_en = 0, tr_hold = 0, ctl_en = 0;
    bit   src_on = 0, sb_on = 0, gap_exact = 0, dut_sel = 0;
    exp_t sb_q[$];
    msg_t ctl_q[$];
    vec_t vt[10];

    always #5 clk = ~clk;

    uart_tx_arbiter_if bus0 ();
    uart_tx_arbiter_if bus1 ();

    assign bus0.trace_avail = d_trace_avail;
    assign bus0.trace_byte  = d_trace_byte;
    assign bus0.ctl_avail   = d_ctl_avail;
    assign bus0.ctl_byte    = d_ctl_byte;
    assign bus0.ctl_last    = d_ctl_last;
    assign bus0.tx_free     = d_tx_free;
    assign bus1.trace_avail = d_trace_avail;
    assign bus1.trace_byte  = d_trace_byte;
    assign bus1.ctl_avail   = d_ctl_avail;
    assign bus1.ctl_byte    = d_ctl_byte;
    assign bus1.ctl_last    = d_ctl_last;
    assign bus1.tx_free     = d_tx_free;

    uart_tx_arbiter #(.FRAME_LEN(16), .MAX_BURST(4), .HOLDOFF(2)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    uart_tx_arbiter #(.FRAME_LEN(16), .MAX_BURST(1), .HOLDOFF(2)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    logic       m_transmit, m_trn, m_ctn, m_grant;
    logic [7:0] m_byte, m_burst;
    assign m_transmit = dut_sel ? bus1.transmit   : bus0.transmit;
    assign m_trn      = dut_sel ? bus1.trace_next : bus0.trace_next;
    assign m_ctn      = dut_sel ? bus1.ctl_next   : bus0.ctl_next;
    assign m_grant    = dut_sel ? bus1.grant_ctl  : bus0.grant_ctl;
    assign m_byte     = dut_sel ? bus1.tx_byte    : bus0.tx_byte;
    assign m_burst    = dut_sel ? bus1.burst_cnt  : bus0.burst_cnt;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void exp_push(input bit is_ctl, input int data, input int burst);
        exp_t e;
        e.is_ctl = is_ctl;
        e.data   = 8'(data);
        e.burst  = burst;
        sb_q.push_back(e);
    endfunction

    function automatic void ctl_push(input int data, input logic last);
        msg_t m;
        m.data = 8'(data);
        m.last = last;
        ctl_q.push_back(m);
    endfunction

    function automatic void drive_sources();
        d_trace_avail = tr_en && !tr_hold && (tr_cnt < tr_limit);
        d_trace_byte  = 8'(tr_cnt);
        d_ctl_avail   = ctl_en && (ctl_q.size() > 0);
        d_ctl_byte    = (ctl_q.size() > 0) ? ctl_q[0].data : 8'h00;
        d_ctl_last    = (ctl_q.size() > 0) ? ctl_q[0].last : 1'b0;
    endfunction

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        chk("next_exclusive", 32'(m_trn & m_ctn), 32'd0);
        chk("tx_vs_next", 32'(m_transmit), 32'(m_trn | m_ctn));
        chk("burst_le_max", 32'(int'(m_burst) <= max_b), 32'd1);
        if (m_trn) chk("grant_during_trace", 32'(m_grant), 32'd0);
        if (m_transmit) begin
            tx_count++;
            if (last_tx >= 0) begin
                if (gap_exact) chk("tx_gap", 32'(cyc - last_tx), 32'd3);
                else           chk("tx_gap_min", 32'(cyc - last_tx >= 3), 32'd1);
            end
            last_tx = cyc;
            if (sb_on) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_tx: got byte 0x%0h, expected no transmit", m_byte);
                end else begin
                    e = sb_q.pop_front();
                    chk("tx_src_ctl", 32'(m_ctn), 32'(e.is_ctl));
                    chk("tx_byte", 32'(m_byte), 32'(e.data));
                    chk("tx_grant", 32'(m_grant), 32'(e.is_ctl));
                    if (e.burst >= 0) chk("tx_burst", 32'(m_burst), 32'(e.burst));
                end
            end
        end
        if (m_trn) tr_cnt++;
        if (m_ctn && ctl_q.size() > 0) void'(ctl_q.pop_front());
        if (src_on) drive_sources();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_tx = -1;
    endtask

    task automatic run_until_empty(input int budget, input string name);
        int n = 0;
        while (sb_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        if (sb_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: %0d transmits outstanding, expected 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic wait_tr(input int target, input int budget, input string name);
        int n = 0;
        while (tr_cnt < target && n < budget) begin
            tick();
            n++;
        end
        if (tr_cnt < target) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: trace count %0d, expected %0d", name, tr_cnt, target);
        end
    endtask

    initial begin
        int n0;
        rst = 1'b1;
        d_trace_avail = 1'b0; d_trace_byte = 8'h00;
        d_ctl_avail = 1'b0; d_ctl_byte = 8'h00; d_ctl_last = 1'b0; d_tx_free = 1'b1;

        // rst, tx_free, tr_av, tr_b, c_av, c_b, c_last | tx, byte, trn, ctn, grant, burst
        vt[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0};
        vt[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h55, 1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 8'd0};
        vt[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 8'd0};
        vt[3] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h66, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 8'd0};
        vt[4] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h66, 1'b1, 1'b1, 8'h66, 1'b0, 1'b1, 1'b1, 8'd0};
        vt[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h66, 1'b0, 1'b0, 1'b0, 8'd0};
        vt[6] = '{1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 8'h00, 1'b0, 1'b0, 8'h66, 1'b0, 1'b0, 1'b0, 8'd0};
        vt[7] = '{1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 8'h00, 1'b0, 1'b0, 8'h66, 1'b0, 1'b0, 1'b0, 8'd0};
        vt[8] = '{1'b0, 1'b1, 1'b1, 8'h12, 1'b0, 8'h00, 1'b0, 1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 8'd0};
        vt[9] = '{1'b1, 1'b1, 1'b1, 8'h34, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0};

        src_on = 0; sb_on = 0; dut_sel = 0; max_b = 4;
        for (int i = 0; i < 10; i++) begin
            rst           = vt[i].rst;
            d_tx_free     = vt[i].tx_free;
            d_trace_avail = vt[i].tr_av;
            d_trace_byte  = vt[i].tr_b;
            d_ctl_avail   = vt[i].c_av;
            d_ctl_byte    = vt[i].c_b;
            d_ctl_last    = vt[i].c_last;
            tick();
            chk($sformatf("vec%0d_transmit", i), 32'(m_transmit), 32'(vt[i].e_tx));
            chk($sformatf("vec%0d_tx_byte", i), 32'(m_byte), 32'(vt[i].e_byte));
            chk($sformatf("vec%0d_trace_next", i), 32'(m_trn), 32'(vt[i].e_trn));
            chk($sformatf("vec%0d_ctl_next", i), 32'(m_ctn), 32'(vt[i].e_ctn));
            chk($sformatf("vec%0d_grant", i), 32'(m_grant), 32'(vt[i].e_grant));
            chk($sformatf("vec%0d_burst", i), 32'(m_burst), 32'(vt[i].e_burst));
        end
        last_tx = -1;

        // Trace only: two full frames, exact spacing, burst count 1 then 2.
        src_on = 1; sb_on = 1; d_tx_free = 1'b1;
        tr_en = 1; tr_hold = 0; tr_cnt = 0; tr_limit = 32; ctl_en = 0; ctl_q.delete();
        do_reset();
        gap_exact = 1;
        for (int i = 0; i < 32; i++) exp_push(1'b0, i, (i + 1) / 16);
        run_until_empty(32 * 3 + 20, "trace_only");
        for (int i = 0; i < 6; i++) tick();
        chk("trace_only_final_burst", 32'(m_burst), 32'd2);

        // Burst limit: both sources always pending, 4 frames then one control message.
        tr_cnt = 0; tr_limit = 128; ctl_en = 1; ctl_q.delete();
        ctl_push(8'hC0, 1'b0); ctl_push(8'hC1, 1'b1);
        ctl_push(8'hD0, 1'b0); ctl_push(8'hD1, 1'b1);
        do_reset();
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 64; i++) exp_push(1'b0, g * 64 + i, (i + 1) / 16);
            exp_push(1'b1, (g == 0) ? 8'hC0 : 8'hD0, 4);
            exp_push(1'b1, (g == 0) ? 8'hC1 : 8'hD1, 0);
        end
        run_until_empty(132 * 3 + 30, "burst_limit");
        chk("burst_limit_final_burst", 32'(m_burst), 32'd0);

        // Stall and backpressure mid-frame; control arriving meanwhile must wait for frame end.
        gap_exact = 0;
        tr_cnt = 0; tr_limit = 16; ctl_en = 1; ctl_q.delete();
        do_reset();
        for (int i = 0; i < 16; i++) exp_push(1'b0, i, (i + 1) / 16);
        exp_push(1'b1, 8'h5A, 0);
        wait_tr(4, 40, "stall_pre");
        d_tx_free = 1'b0;
        n0 = tx_count;
        for (int i = 0; i < 20; i++) tick();
        chk("stall_txfree_no_tx", 32'(tx_count - n0), 32'd0);
        d_tx_free = 1'b1;
        wait_tr(7, 40, "stall_mid");
        tr_hold = 1;
        ctl_push(8'h5A, 1'b1);
        drive_sources();
        n0 = tx_count;
        for (int i = 0; i < 10; i++) tick();
        chk("stall_avail_no_tx", 32'(tx_count - n0), 32'd0);
        chk("stall_grant_held_off", 32'(m_grant), 32'd0);
        tr_hold = 0;
        drive_sources();
        run_until_empty(12 * 3 + 30, "stall_resume");

        // Reset in the middle of a control message.
        tr_en = 0; tr_cnt = 0; tr_limit = 0; ctl_en = 1; ctl_q.delete();
        ctl_push(8'hA1, 1'b0); ctl_push(8'hA2, 1'b0); ctl_push(8'hA3, 1'b1);
        do_reset();
        exp_push(1'b1, 8'hA1, 0);
        run_until_empty(10, "midrst_first");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_tx = -1;
        chk("midrst_transmit", 32'(m_transmit), 32'd0);
        chk("midrst_tx_byte", 32'(m_byte), 32'h00);
        chk("midrst_grant", 32'(m_grant), 32'd0);
        chk("midrst_burst", 32'(m_burst), 32'd0);
        chk("midrst_nexts", 32'({m_trn, m_ctn}), 32'd0);
        tr_en = 1; tr_limit = 16;
        drive_sources();
        for (int i = 0; i < 16; i++) exp_push(1'b0, i, (i + 1) / 16);
        exp_push(1'b1, 8'hA2, 1);
        exp_push(1'b1, 8'hA3, 0);
        run_until_empty(18 * 3 + 20, "midrst_after");

        // Boundary switch with MAX_BURST=1: control raised at trace byte 5 waits for frame end.
        dut_sel = 1; max_b = 1; gap_exact = 1;
        tr_en = 1; tr_cnt = 0; tr_limit = 17; ctl_en = 1; ctl_q.delete();
        do_reset();
        for (int i = 0; i < 16; i++) exp_push(1'b0, i, (i + 1) / 16);
        exp_push(1'b1, 8'hA1, 1);
        exp_push(1'b1, 8'hA2, 1);
        exp_push(1'b1, 8'hA3, 0);
        exp_push(1'b0, 16, 0);
        wait_tr(5, 40, "boundary_pre");
        ctl_push(8'hA1, 1'b0); ctl_push(8'hA2, 1'b0); ctl_push(8'hA3, 1'b1);
        drive_sources();
        run_until_empty(20 * 3 + 20, "boundary");
        for (int i = 0; i < 6; i++) tick();
        chk("boundary_final_burst", 32'(m_burst), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between two byte sources: the trace byte stream from the packet splitter, and the host-response/control message stream from the command handler.
- Switches source only at frame boundaries: trace at FRAME_LEN-byte boundaries, control at message end (ctl_last).
- Guarantees control bandwidth with a trace burst limit.
- Sits between packSend/command handler and uart, replacing the direct doTransmit = dataAvail & txFree gating.

Parameters:
FRAME_LEN, 16, trace bytes per indivisible trace frame (power of 2, 2..256)
MAX_BURST, 4, trace frames granted back-to-back before a pending control message must be served (1..255)
HOLDOFF, 2, cycles after each transmit pulse during which tx_free and source avail are ignored (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
trace_avail  in  1  trace byte available
trace_byte  in  8  trace byte, valid while trace_avail=1
trace_next  out  1  one-cycle pulse: trace byte consumed
ctl_avail  in  1  control byte available
ctl_byte  in  8  control byte, valid while ctl_avail=1
ctl_last  in  1  qualifies ctl_byte as final byte of a control message
ctl_next  out  1  one-cycle pulse: control byte consumed
tx_free  in  1  UART ready to accept a byte
transmit  out  1  one-cycle pulse to UART
tx_byte  out  8  byte to UART, stable from transmit pulse until next transmit
grant_ctl  out  1  1 while control source owns the transmitter
burst_cnt  out  8  trace frames sent since last control message (saturating at MAX_BURST)

Behaviour:
- Reset: synchronous, active-high; one clock is the only clock. On rst=1 at a clock edge:
  - State becomes IDLE.
  - transmit, trace_next, ctl_next, grant_ctl = 0; tx_byte = 8'h00; burst_cnt = 0.
  - Byte index = 0; holdoff counter = 0.
  - Any partially sent frame or message is abandoned; there is no resume.
- States: IDLE (no owner), TRACE (trace owns, mid-frame), CTL (control owns, mid-message).
- Issue condition, evaluated each cycle: holdoff=0 AND tx_free=1 AND the selected source's avail=1.
- On issue, at the next edge:
  - transmit=1.
  - tx_byte = the source byte.
  - The source's next=1 for exactly one cycle.
  - Holdoff counter loaded with HOLDOFF.
  - Latency is 1 cycle from the issue condition to the transmit pulse.
- Holdoff decrements each cycle to 0. There is never more than one transmit in any HOLDOFF+1 window.
- Source selection in IDLE:
  - Control is selected if ctl_avail=1 AND (trace_avail=0 OR burst_cnt>=MAX_BURST).
  - Otherwise trace is selected if trace_avail=1.
  - Otherwise no selection; stay IDLE.
  - Selection and the first issue occur in the same cycle. The state moves to TRACE/CTL on that issue edge, unless the issued byte is itself terminal, in which case the state stays IDLE.
- TRACE:
  - Byte index increments on each trace issue.
  - When a byte with index FRAME_LEN-1 is issued: index wraps to 0, burst_cnt increments (saturating at MAX_BURST), and the state returns to IDLE.
  - trace_avail=0 mid-frame: ownership is held indefinitely and control waits. No timeout.
- CTL:
  - grant_ctl=1 from the first control issue edge until the edge that issues the byte with ctl_last=1.
  - At that edge the state goes to IDLE and burst_cnt is cleared to 0.
  - ctl_avail=0 mid-message: ownership is held.
- Simultaneous requests in IDLE with burst_cnt<MAX_BURST: trace wins. With burst_cnt=MAX_BURST: control wins.
- Only control pending: control is served regardless of burst_cnt.
- Single-byte control message (ctl_last on its first byte): one transmit, grant_ctl pulses for one cycle, burst_cnt cleared.
- Avail inputs are sampled only in issue cycles. A source dropping avail during holdoff is legal.
- A next pulse never coincides with a cycle where the corresponding avail was 0 at the issue evaluation.
- trace_next and ctl_next are never asserted in the same cycle. grant_ctl=0 whenever trace_next=1.

Test Plan:
- Reset then trace only: trace_avail=1 with bytes 0x00..0x1F, tx_free=1 → 32 transmit pulses carrying 0x00..0x1F in order, each HOLDOFF+1=3 cycles apart; burst_cnt 1 after byte 0x0F, 2 after 0x1F; ctl_next never pulses.
- Boundary switch: trace continuous, ctl_avail raised at trace byte 5 with a 3-byte message 0xA1,0xA2,0xA3 (last on 0xA3), MAX_BURST=1 → trace bytes 5..15 complete first, then 0xA1,0xA2,0xA3 with grant_ctl=1, then trace byte 16; burst_cnt 1→0.
- Burst limit: both sources always available, defaults → sequence is 4 trace frames (64 bytes), 1 control message, 4 trace frames, repeating; burst_cnt never exceeds 4.
- Stall and backpressure: tx_free=0 for 20 cycles mid-frame, then trace_avail=0 for 10 cycles at byte 7 → no transmit while either is low; transmission resumes at byte 7 with the same owner, no byte lost or duplicated.
- Mid-operation reset: rst=1 for one cycle during a control message after 0xA1 → all outputs 0 and tx_byte=0x00 on the next cycle; state IDLE; next grant follows the IDLE rules with burst_cnt=0.
- Single-byte control: ctl_byte=0x55 with ctl_last=1, no trace → exactly one transmit of 0x55, one ctl_next pulse, grant_ctl high one cycle.
